// File: rtl/step_sequencer.sv
// Run-control scheduler: issues one step pulse per instruction and stops on halt, count or breakpoint.
// Optional breakpoint logic is enabled by defining STEP_SEQ_BREAKPOINT_EN.
module step_sequencer #(
   parameter int PC_W  = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_step,
   input  logic             cmd_run,
   input  logic             cmd_run_n,
   input  logic [CNT_W-1:0] run_count,
   input  logic             cmd_halt,
   input  logic             cpu_idle,
   input  logic [PC_W-1:0]  cpu_pc,
   input  logic             bp_valid,
   input  logic [PC_W-1:0]  bp_addr,
   output logic             step,
   output logic             halted,
   output logic             bp_hit,
   output logic [CNT_W-1:0] retired_count,
   output logic [1:0]       state_dbg
);

   // Handshake with the controller: step is held for exactly one cycle (ISSUE);
   // the instruction is in flight from the cycle cpu_idle drops until it rises again.

   typedef enum logic [1:0] {S_HALT, S_ISSUE, S_WAIT_LEAVE, S_WAIT_IDLE} state_t;
   typedef enum logic [1:0] {M_STEP, M_RUN, M_RUN_N} mode_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_n;
   mode_t            mode, mode_n;
   logic [CNT_W-1:0] remaining, remaining_n;
   logic [CNT_W-1:0] retired_n;
   logic [CNT_W-1:0] rem_dec;
   logic             halt_pend, halt_pend_n;
   logic             bp_hit_q, bp_hit_n;
   logic             bp_match;
   logic             halt_now;

`ifdef STEP_SEQ_BREAKPOINT_EN
   assign bp_match = bp_valid && (cpu_pc == bp_addr);
`else
   logic unused_bp;
   assign unused_bp = ^{bp_valid, bp_addr, cpu_pc};
   assign bp_match  = 1'b0;
`endif

   assign rem_dec  = remaining - CNT_ONE;
   // A halt arriving in the retire cycle itself must stop at that same boundary.
   assign halt_now = halt_pend | cmd_halt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_HALT;
         mode          <= M_STEP;
         remaining     <= '0;
         retired_count <= '0;
         halt_pend     <= 1'b0;
         bp_hit_q      <= 1'b0;
      end else begin
         state         <= state_n;
         mode          <= mode_n;
         remaining     <= remaining_n;
         retired_count <= retired_n;
         halt_pend     <= halt_pend_n;
         bp_hit_q      <= bp_hit_n;
      end
   end

   always_comb begin
      state_n     = state;
      mode_n      = mode;
      remaining_n = remaining;
      retired_n   = retired_count;
      halt_pend_n = halt_pend;
      bp_hit_n    = bp_hit_q;

      if (state != S_HALT && cmd_halt)
         halt_pend_n = 1'b1;

      case (state)
         S_HALT: begin
            if (cpu_idle && !cmd_halt) begin
               if (cmd_step) begin
                  mode_n      = M_STEP;
                  state_n     = S_ISSUE;
               end else if (cmd_run_n && run_count != '0) begin
                  mode_n      = M_RUN_N;
                  remaining_n = run_count;
                  state_n     = S_ISSUE;
               end else if (cmd_run) begin
                  mode_n      = M_RUN;
                  state_n     = S_ISSUE;
               end
               if (state_n == S_ISSUE) begin
                  halt_pend_n = 1'b0;
                  bp_hit_n    = 1'b0;
               end
            end
         end
         S_ISSUE: state_n = S_WAIT_LEAVE;
         S_WAIT_LEAVE: begin
            if (!cpu_idle)
               state_n = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (cpu_idle) begin
               retired_n = retired_count + CNT_ONE;
               if (mode == M_RUN_N)
                  remaining_n = rem_dec;
               if (halt_now) begin
                  state_n = S_HALT;
               end else if (bp_match) begin
                  state_n  = S_HALT;
                  bp_hit_n = 1'b1;
               end else if (mode == M_STEP) begin
                  state_n = S_HALT;
               end else if (mode == M_RUN_N && rem_dec == '0) begin
                  state_n = S_HALT;
               end else begin
                  state_n = S_ISSUE;
               end
            end
         end
         default: state_n = S_HALT;
      endcase
   end

   assign step      = (state == S_ISSUE);
   assign halted    = (state == S_HALT);
   assign state_dbg = state;
`ifdef STEP_SEQ_BREAKPOINT_EN
   assign bp_hit    = bp_hit_q;
`else
   assign bp_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with a Fetch/Decode/Execute/Idle controller model.
module tb_step_sequencer;
   localparam int PC_W  = 6;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_step, cmd_run, cmd_run_n, cmd_halt;
   logic [CNT_W-1:0] run_count;
   logic             cpu_idle;
   logic [PC_W-1:0]  cpu_pc;
   logic             bp_valid;
   logic [PC_W-1:0]  bp_addr;
   logic             step, halted, bp_hit;
   logic [CNT_W-1:0] retired_count;
   logic [1:0]       state_dbg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   step_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_step(cmd_step), .cmd_run(cmd_run), .cmd_run_n(cmd_run_n),
      .run_count(run_count), .cmd_halt(cmd_halt),
      .cpu_idle(cpu_idle), .cpu_pc(cpu_pc),
      .bp_valid(bp_valid), .bp_addr(bp_addr),
      .step(step), .halted(halted), .bp_hit(bp_hit),
      .retired_count(retired_count), .state_dbg(state_dbg)
   );

   // Controller model: 3 busy cycles per step, pc advances as Execute ends.
   logic       cpu_rst_n;
   logic [1:0] cpu_cnt;
   always @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         cpu_cnt <= 2'd0;
         cpu_pc  <= '0;
      end else if (cpu_cnt == 2'd0) begin
         if (step) cpu_cnt <= 2'd3;
      end else begin
         cpu_cnt <= cpu_cnt - 2'd1;
         if (cpu_cnt == 2'd1) cpu_pc <= cpu_pc + 6'd1;
      end
   end
   assign cpu_idle = (cpu_cnt == 2'd0);

   int cyc = 0;
   int step_cnt = 0;
   int last_step_cyc = 0;
   int step_gap = 0;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (step) begin
         step_gap      = cyc - last_step_cyc;
         last_step_cyc = cyc;
         step_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; cpu_rst_n = 1'b0;
      cmd_step = 0; cmd_run = 0; cmd_run_n = 0; cmd_halt = 0; run_count = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1; cpu_rst_n = 1'b1;
   endtask

   task automatic send(input logic s, input logic r, input logic rn, input logic h,
                       input logic [CNT_W-1:0] cnt);
      @(posedge clk);
      #1 cmd_step = s; cmd_run = r; cmd_run_n = rn; cmd_halt = h; run_count = cnt;
      @(posedge clk);
      #1 cmd_step = 0; cmd_run = 0; cmd_run_n = 0; cmd_halt = 0; run_count = '0;
   endtask

   task automatic wait_halt(input int budget, input string tag);
      int n = 0;
      @(negedge clk);
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, halted, 1);
   endtask

   task automatic wait_steps(input int target, input int budget, input string tag);
      int n = 0;
      while (step_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, step_cnt >= target, 1);
   endtask

   int s0;

   initial begin
      bp_valid = 1'b0;
      bp_addr  = '0;
      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_halted", halted, 1);
      check("rst_step", step, 0);
      check("rst_bp_hit", bp_hit, 0);
      check("rst_retired", retired_count, 0);
      check("rst_state", state_dbg, 0);

      // Single step
      s0 = step_cnt;
      send(1, 0, 0, 0, '0);
      @(negedge clk);
      check("step_hi", step, 1);
      check("step_not_halted", halted, 0);
      @(negedge clk);
      check("step_lo", step, 0);
      wait_halt(10, "step_halt");
      check("step_retired", retired_count, 1);
      repeat (10) @(negedge clk);
      check("step_one_pulse", step_cnt - s0, 1);

      // Run-N with 3, then run-N with 0
      do_reset();
      s0 = step_cnt;
      send(0, 0, 1, 0, 4'd3);
      wait_halt(30, "runn_halt");
      check("runn_pulses", step_cnt - s0, 3);
      check("runn_gap", step_gap, 5);
      check("runn_retired", retired_count, 3);
      s0 = step_cnt;
      send(0, 0, 1, 0, 4'd0);
      repeat (8) @(negedge clk);
      check("runn0_pulses", step_cnt - s0, 0);
      check("runn0_halted", halted, 1);
      check("runn0_retired", retired_count, 3);

      // Free run, halt one cycle after the 4th pulse
      do_reset();
      s0 = step_cnt;
      send(0, 1, 0, 0, '0);
      wait_steps(s0 + 4, 40, "run_4_steps");
      send(0, 0, 0, 1, '0);
      wait_halt(10, "run_halt");
      check("run_retired", retired_count, 4);
      repeat (10) @(negedge clk);
      check("run_no_5th", step_cnt - s0, 4);

      // Breakpoint at pc 3
      do_reset();
      bp_valid = 1'b1;
      bp_addr  = 6'h03;
      s0 = step_cnt;
      send(0, 1, 0, 0, '0);
`ifdef STEP_SEQ_BREAKPOINT_EN
      wait_halt(40, "bp_halt");
      check("bp_retired", retired_count, 3);
      check("bp_hit_set", bp_hit, 1);
      check("bp_pulses", step_cnt - s0, 3);
      send(1, 0, 0, 0, '0);
      @(negedge clk);
      check("bp_hit_clr", bp_hit, 0);
      wait_halt(10, "bp_step_halt");
      check("bp_step_retired", retired_count, 4);
      check("bp_hit_still_clr", bp_hit, 0);
`else
      wait_steps(s0 + 5, 50, "nobp_5_steps");
      send(0, 0, 0, 1, '0);
      wait_halt(10, "nobp_halt");
      check("nobp_retired", retired_count, 5);
      check("nobp_bp_hit", bp_hit, 0);
`endif
      bp_valid = 1'b0;

      // Async reset mid-instruction
      do_reset();
      send(1, 0, 0, 0, '0);
      wait_halt(10, "areset_step1");
      check("areset_pre_retired", retired_count, 1);
      send(1, 0, 0, 0, '0);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("areset_halted", halted, 1);
      check("areset_step", step, 0);
      check("areset_retired", retired_count, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      begin
         int n = 0;
         while (!cpu_idle && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("areset_cpu_idle", cpu_idle, 1);
      end

      // Simultaneous step+run gives one step; halt beats step
      s0 = step_cnt;
      send(1, 1, 0, 0, '0);
      wait_halt(10, "prio_halt");
      repeat (10) @(negedge clk);
      check("prio_one_step", step_cnt - s0, 1);
      check("prio_retired", retired_count, 1);
      s0 = step_cnt;
      send(1, 0, 0, 1, '0);
      repeat (8) @(negedge clk);
      check("prio_halt_wins", step_cnt - s0, 0);
      check("prio_halted", halted, 1);

      // Retired counter wraps at 4 bits
      do_reset();
      s0 = step_cnt;
      send(0, 1, 0, 0, '0);
      wait_steps(s0 + 17, 17 * 5 + 20, "wrap_17_steps");
      send(0, 0, 0, 1, '0);
      wait_halt(10, "wrap_halt");
      check("wrap_retired", retired_count, 1);
      repeat (10) @(negedge clk);
      check("wrap_pulses", step_cnt - s0, 17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Run-control scheduler that drives the CPU controller's step input and sequences instruction execution for debug and stepped operation. It accepts single-step, free-run, run-N and halt commands, and issues one step pulse per instruction. Retirement is tracked through the controller's idle output, and the block halts on command, on count exhaustion, or on a PC breakpoint. It sits between the board-level debug inputs and the CPU controller.

Parameters:
PC_W, 6, width of program counter and breakpoint address
CNT_W, 8, width of run-N count and retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
cmd_step  input  1  one-cycle pulse: execute exactly one instruction
cmd_run  input  1  one-cycle pulse: free-run until halted
cmd_run_n  input  1  one-cycle pulse: run run_count instructions
run_count  input  CNT_W  instruction count, sampled when cmd_run_n is accepted
cmd_halt  input  1  one-cycle pulse: stop at next instruction boundary
cpu_idle  input  1  controller idle flag (1 = CPU waiting for step)
cpu_pc  input  PC_W  current CPU program counter
bp_valid  input  1  breakpoint enable
bp_addr  input  PC_W  breakpoint address
step  output  1  step request to the controller, exactly one cycle per instruction
halted  output  1  1 when in HALT
bp_hit  output  1  sticky: last stop was caused by the breakpoint
retired_count  output  CNT_W  instructions retired since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): state=HALT, step=0, halted=1, bp_hit=0, retired_count=0, remaining=0, mode=STEP, halt_pend=0.
- States: HALT, ISSUE, WAIT_LEAVE, WAIT_IDLE. step=1 only in ISSUE (registered Moore output). halted=1 only in HALT.
- HALT: commands are accepted only while cpu_idle=1. If several arrive together, priority is cmd_halt (no-op) > cmd_step > cmd_run_n > cmd_run.
  - Accepting any step/run command clears bp_hit and halt_pend.
  - cmd_run_n with run_count=0 is ignored, and bp_hit is unchanged.
  - An accepted command latches mode (STEP/RUN/RUN_N), sets remaining=run_count for RUN_N, and moves to ISSUE.
- ISSUE: lasts one cycle, then WAIT_LEAVE.
- WAIT_LEAVE: stays until cpu_idle=0, then WAIT_IDLE.
- WAIT_IDLE: stays until cpu_idle=1. That cycle is the retire cycle:
  - retired_count += 1.
  - For RUN_N, remaining -= 1.
  - Stop conditions, evaluated in order:
    - halt_pend=1 → HALT.
    - bp match (feature) → HALT, bp_hit=1.
    - mode=STEP → HALT.
    - mode=RUN_N and remaining becomes 0 → HALT.
    - Otherwise → ISSUE.
- Cycle timing with the controller's Fetch/Decode/Execute/Idle:
  - Step pulse in cycle t; retire detected in cycle t+4.
  - Next step in cycle t+5, so free-run is 5 cycles per instruction.
- cmd_halt while not in HALT sets halt_pend. An instruction in flight is never aborted, and step is never withdrawn once issued.
- cmd_step/cmd_run/cmd_run_n outside HALT are ignored.
- cmd_halt in the retire cycle sets halt_pend, and the stop is taken in that same retire evaluation.
- Breakpoint is checked only at retire, against cpu_pc (the next instruction to execute). Resuming from a breakpoint therefore executes at least one instruction.
- Asserting reset mid-instruction returns to HALT immediately. The CPU controller's own reset is independent.

Optional Feature:
STEP_SEQ_BREAKPOINT_EN
- Defined: bp match = bp_valid && (cpu_pc == bp_addr) at retire, with behaviour as above.
- Undefined: bp_valid/bp_addr ports remain but are ignored, bp_hit is tied to 0, and no breakpoint logic is synthesised.

Test Plan:
- Reset, then cpu model reaches idle; pulse cmd_step → step=1 for exactly 1 cycle, retired_count=1 after 5 cycles, halted=1, no second step.
- cmd_run_n with run_count=3 → exactly 3 step pulses spaced 5 cycles apart, retired_count=3, halted=1; run_count=0 → no step, halted stays 1.
- cmd_run, then cmd_halt one cycle after the 4th step pulse → 4th instruction completes, retired_count=4, halted=1, no 5th step.
- With STEP_SEQ_BREAKPOINT_EN: bp_valid=1, bp_addr=6'h03, program increments pc from 0, cmd_run → halt with cpu_pc=3, bp_hit=1, retired_count=3. Then cmd_step → bp_hit=0 and one more instruction retires.
- Assert reset=0 between step and retire → halted=1, step=0, retired_count=0 asynchronously. Simultaneous cmd_step+cmd_run in HALT → single step only.
- Retired counter wrap with CNT_W=4: run 17 instructions → retired_count=1.
